// File: rtl/chroma_qp_derive_if.sv
// rtl/chroma_qp_derive_if.sv - request, chroma_scale_rom and result signals of chroma_qp_derive
interface chroma_qp_derive_if #(parameter int TABLE_LEN = 58);
  localparam int AW = $clog2(TABLE_LEN);

  logic          in_valid;
  logic          in_ready;
  logic [6:0]    in_qp_y;
  logic [4:0]    in_pps_cb_ofs;
  logic [4:0]    in_slice_cb_ofs;
  logic [4:0]    in_pps_cr_ofs;
  logic [4:0]    in_slice_cr_ofs;
  logic [1:0]    in_chroma_fmt;
  logic [4:0]    in_bit_depth_c;

  logic [1:0]    rom_fmt;
  logic [AW-1:0] rom_addr;
  logic [7:0]    rom_data;

  logic          out_valid;
  logic          out_ready;
  logic [6:0]    out_qp_cb;
  logic [6:0]    out_qp_cr;
  logic [4:0]    out_per_cb;
  logic [4:0]    out_per_cr;
  logic [2:0]    out_rem_cb;
  logic [2:0]    out_rem_cr;
  logic          out_cfg_err;

  modport slave (
    input  in_valid, in_qp_y, in_pps_cb_ofs, in_slice_cb_ofs, in_pps_cr_ofs,
           in_slice_cr_ofs, in_chroma_fmt, in_bit_depth_c, rom_data, out_ready,
    output in_ready, rom_fmt, rom_addr, out_valid, out_qp_cb, out_qp_cr,
           out_per_cb, out_per_cr, out_rem_cb, out_rem_cr, out_cfg_err
  );

  modport master (
    output in_valid, in_qp_y, in_pps_cb_ofs, in_slice_cb_ofs, in_pps_cr_ofs,
           in_slice_cr_ofs, in_chroma_fmt, in_bit_depth_c, rom_data, out_ready,
    input  in_ready, rom_fmt, rom_addr, out_valid, out_qp_cb, out_qp_cr,
           out_per_cb, out_per_cr, out_rem_cb, out_rem_cr, out_cfg_err
  );
endinterface

// File: rtl/chroma_qp_derive.sv
// rtl/chroma_qp_derive.sv - per-TU Cb/Cr QP derivation with ROM mapping and iterative divide-by-6
module chroma_qp_derive #(
  parameter int TABLE_LEN = 58
) (
  input logic               clk,
  input logic               rst,
  chroma_qp_derive_if.slave bus
);
  localparam int AW = $clog2(TABLE_LEN);

  typedef enum logic [2:0] {IDLE, CB_IDX, CB_DIV, CR_IDX, CR_DIV, DONE} state_t;

  state_t            state;
  logic [1:0]        fmt_r;
  logic [5:0]        bdofs_r;
  logic signed [7:0] qpi_cb_r;
  logic signed [7:0] qpi_cr_r;
  logic              err_r;
  logic [6:0]        qp_r;
  logic [6:0]        div_rem;
  logic [4:0]        div_per;

  logic              bd_ok;
  logic [3:0]        bd_delta;
  logic [5:0]        bdofs_n;
  logic signed [7:0] qpi_cb_n;
  logic signed [7:0] qpi_cr_n;
  logic signed [7:0] qpi_cur;
  logic signed [9:0] qpc;
  logic signed [9:0] qp_sum;
  logic [6:0]        qp_prime;

  function automatic logic signed [7:0] sext5(input logic [4:0] v);
    return {{3{v[4]}}, v};
  endfunction

  function automatic logic signed [7:0] clip_qpi(input logic signed [7:0] sum,
                                                 input logic [5:0] ofs);
    logic signed [7:0] lo;
    lo = -$signed({2'b00, ofs});
    if (sum < lo) return lo;
    if (sum > 8'sd57) return 8'sd57;
    return sum;
  endfunction

  function automatic logic [AW-1:0] qpi_addr(input logic signed [7:0] q);
    return q[7] ? '0 : q[AW-1:0];
  endfunction

  // Offset sums are formed at 8-bit signed width before clipping.
  always_comb begin
    bd_ok    = (bus.in_bit_depth_c >= 5'd8) && (bus.in_bit_depth_c <= 5'd16);
    bd_delta = bd_ok ? 4'(bus.in_bit_depth_c - 5'd8) : 4'd0;
    bdofs_n  = {bd_delta, 2'b00} + {1'b0, bd_delta, 1'b0};
    qpi_cb_n = clip_qpi({bus.in_qp_y[6], bus.in_qp_y} + sext5(bus.in_pps_cb_ofs)
                        + sext5(bus.in_slice_cb_ofs), bdofs_n);
    qpi_cr_n = clip_qpi({bus.in_qp_y[6], bus.in_qp_y} + sext5(bus.in_pps_cr_ofs)
                        + sext5(bus.in_slice_cr_ofs), bdofs_n);
    qpi_cur  = (state == CR_IDX) ? qpi_cr_r : qpi_cb_r;
    qpc      = qpi_cur[7] ? {{2{qpi_cur[7]}}, qpi_cur} : {2'b00, bus.rom_data};
    qp_sum   = qpc + $signed({4'b0000, bdofs_r});
    qp_prime = qp_sum[6:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      bus.in_ready    <= 1'b1;
      bus.out_valid   <= 1'b0;
      bus.rom_fmt     <= 2'd0;
      bus.rom_addr    <= '0;
      bus.out_qp_cb   <= 7'd0;
      bus.out_qp_cr   <= 7'd0;
      bus.out_per_cb  <= 5'd0;
      bus.out_per_cr  <= 5'd0;
      bus.out_rem_cb  <= 3'd0;
      bus.out_rem_cr  <= 3'd0;
      bus.out_cfg_err <= 1'b0;
      fmt_r           <= 2'd0;
      bdofs_r         <= 6'd0;
      qpi_cb_r        <= 8'sd0;
      qpi_cr_r        <= 8'sd0;
      err_r           <= 1'b0;
      qp_r            <= 7'd0;
      div_rem         <= 7'd0;
      div_per         <= 5'd0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            fmt_r        <= bus.in_chroma_fmt;
            bdofs_r      <= bdofs_n;
            qpi_cb_r     <= qpi_cb_n;
            qpi_cr_r     <= qpi_cr_n;
            err_r        <= ~bd_ok;
            bus.in_ready <= 1'b0;
            if (bus.in_chroma_fmt == 2'd0) begin
              // Monochrome: no chroma QPs, skip the ROM entirely.
              state           <= DONE;
              bus.out_valid   <= 1'b1;
              bus.out_cfg_err <= ~bd_ok;
              bus.out_qp_cb   <= 7'd0;
              bus.out_qp_cr   <= 7'd0;
              bus.out_per_cb  <= 5'd0;
              bus.out_per_cr  <= 5'd0;
              bus.out_rem_cb  <= 3'd0;
              bus.out_rem_cr  <= 3'd0;
            end else begin
              state        <= CB_IDX;
              bus.rom_fmt  <= bus.in_chroma_fmt;
              bus.rom_addr <= qpi_addr(qpi_cb_n);
            end
          end
        end
        CB_IDX, CR_IDX: begin
          qp_r    <= qp_prime;
          div_rem <= qp_prime;
          div_per <= 5'd0;
          state   <= (state == CB_IDX) ? CB_DIV : CR_DIV;
        end
        CB_DIV: begin
          if (div_rem >= 7'd6) begin
            div_rem <= div_rem - 7'd6;
            div_per <= div_per + 5'd1;
          end else begin
            bus.out_qp_cb  <= qp_r;
            bus.out_per_cb <= div_per;
            bus.out_rem_cb <= div_rem[2:0];
            bus.rom_fmt    <= fmt_r;
            bus.rom_addr   <= qpi_addr(qpi_cr_r);
            state          <= CR_IDX;
          end
        end
        CR_DIV: begin
          if (div_rem >= 7'd6) begin
            div_rem <= div_rem - 7'd6;
            div_per <= div_per + 5'd1;
          end else begin
            bus.out_qp_cr   <= qp_r;
            bus.out_per_cr  <= div_per;
            bus.out_rem_cr  <= div_rem[2:0];
            bus.out_cfg_err <= err_r;
            bus.out_valid   <= 1'b1;
            state           <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            bus.in_ready  <= 1'b1;
            state         <= IDLE;
          end
        end
        default: begin
          state        <= IDLE;
          bus.in_ready <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_chroma_qp_derive.sv
// tb/tb_chroma_qp_derive.sv - directed bench with arithmetic reference model for chroma_qp_derive
module tb_chroma_qp_derive;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  chroma_qp_derive_if #(.TABLE_LEN(58)) bus();
  chroma_qp_derive #(.TABLE_LEN(58)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int failures = 0;
  int e_qp[2];
  int e_per[2];
  int e_rem[2];
  int e_err;
  int e_lat;
  bit live = 1'b0;
  int a0;

  // External chroma_scale_rom contents: 4:2:0 mapping table, Min(qPi,51) otherwise.
  function automatic int rom_model(int fmt, int a);
    int t[14] = '{29, 30, 31, 32, 33, 33, 34, 34, 35, 35, 36, 36, 37, 37};
    if (fmt == 1) begin
      if (a < 30) return a;
      if (a <= 43) return t[a-30];
      return a - 6;
    end
    return (a > 51) ? 51 : a;
  endfunction

  always_comb bus.rom_data = 8'(rom_model(int'(bus.rom_fmt), int'(bus.rom_addr)));

  function automatic void model(int qp, int pcb, int scb, int pcr, int scr, int fmt, int bd);
    int b, ofs, s, qpi, qpc, q;
    int p[2];
    b      = (bd < 8 || bd > 16) ? 8 : bd;
    e_err  = (b != bd) ? 1 : 0;
    ofs    = 6 * (b - 8);
    p[0]   = pcb + scb;
    p[1]   = pcr + scr;
    for (int x = 0; x < 2; x++) begin
      s   = qp + p[x];
      qpi = (s < -ofs) ? -ofs : ((s > 57) ? 57 : s);
      qpc = (qpi < 0) ? qpi : rom_model(fmt, qpi);
      q   = (fmt == 0) ? 0 : qpc + ofs;
      e_qp[x]  = q;
      e_per[x] = q / 6;
      e_rem[x] = q % 6;
    end
    e_lat = (fmt == 0) ? 1 : e_per[0] + e_per[1] + 5;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && live && bus.out_valid) begin
      chk("cmp_qp_cb", int'(bus.out_qp_cb), e_qp[0]);
      chk("cmp_qp_cr", int'(bus.out_qp_cr), e_qp[1]);
      chk("cmp_per_cb", int'(bus.out_per_cb), e_per[0]);
      chk("cmp_per_cr", int'(bus.out_per_cr), e_per[1]);
      chk("cmp_rem_cb", int'(bus.out_rem_cb), e_rem[0]);
      chk("cmp_rem_cr", int'(bus.out_rem_cr), e_rem[1]);
      chk("cmp_cfg_err", int'(bus.out_cfg_err), e_err);
      chk("cmp_in_ready_busy", int'(bus.in_ready), 0);
    end
  end

  task automatic start_req(input int qp, pcb, scb, pcr, scr, fmt, bd);
    int n;
    model(qp, pcb, scb, pcr, scr, fmt, bd);
    @(negedge clk);
    n = 0;
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("wait_in_ready_timeout", n, 0);
    bus.in_qp_y         = 7'(qp);
    bus.in_pps_cb_ofs   = 5'(pcb);
    bus.in_slice_cb_ofs = 5'(scb);
    bus.in_pps_cr_ofs   = 5'(pcr);
    bus.in_slice_cr_ofs = 5'(scr);
    bus.in_chroma_fmt   = 2'(fmt);
    bus.in_bit_depth_c  = 5'(bd);
    bus.in_valid        = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic run_req(input string tag, input int qp, pcb, scb, pcr, scr, fmt, bd, hold);
    int n;
    live = 1'b1;
    start_req(qp, pcb, scb, pcr, scr, fmt, bd);
    n = 1;
    while (!bus.out_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_latency"}, n, e_lat);
    repeat (hold) @(negedge clk);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk({tag, "_valid_dropped"}, int'(bus.out_valid), 0);
    chk({tag, "_in_ready_back"}, int'(bus.in_ready), 1);
  endtask

  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.in_qp_y = '0;
    bus.in_pps_cb_ofs = '0;
    bus.in_slice_cb_ofs = '0;
    bus.in_pps_cr_ofs = '0;
    bus.in_slice_cr_ofs = '0;
    bus.in_chroma_fmt = '0;
    bus.in_bit_depth_c = 5'd8;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", int'(bus.in_ready), 1);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_qp_cb", int'(bus.out_qp_cb), 0);
    chk("rst_rom_addr", int'(bus.rom_addr), 0);
    chk("rst_rom_fmt", int'(bus.rom_fmt), 0);
    rst = 1'b0;

    run_req("v1", 30, 0, 0, 0, 0, 1, 8, 0);
    chk("v1_lat_lit", e_lat, 13);
    chk("v1_qp_cb", int'(bus.out_qp_cb), 29);
    chk("v1_qp_cr", int'(bus.out_qp_cr), 29);
    chk("v1_per_cb", int'(bus.out_per_cb), 4);
    chk("v1_rem_cr", int'(bus.out_rem_cr), 5);
    chk("v1_rom_addr", int'(bus.rom_addr), 30);

    run_req("v2", -12, -12, 0, 12, 12, 1, 10, 0);
    chk("v2_qp_cb", int'(bus.out_qp_cb), 0);
    chk("v2_per_cb", int'(bus.out_per_cb), 0);
    chk("v2_qp_cr", int'(bus.out_qp_cr), 24);
    chk("v2_per_cr", int'(bus.out_per_cr), 4);
    chk("v2_rem_cr", int'(bus.out_rem_cr), 0);
    chk("v2_rom_addr", int'(bus.rom_addr), 12);

    run_req("v3", 51, 12, 12, 0, 0, 2, 8, 0);
    chk("v3_qp_cb", int'(bus.out_qp_cb), 51);
    chk("v3_per_cb", int'(bus.out_per_cb), 8);
    chk("v3_rem_cb", int'(bus.out_rem_cb), 3);

    run_req("v4", 51, 0, 0, 0, 0, 3, 16, 0);
    chk("v4_qp_cr", int'(bus.out_qp_cr), 99);
    chk("v4_per_cr", int'(bus.out_per_cr), 16);
    chk("v4_rem_cr", int'(bus.out_rem_cr), 3);
    chk("v4_lat_lit", e_lat, 37);

    a0 = int'(bus.rom_addr);
    run_req("v5", 40, 3, 3, 3, 3, 0, 9, 0);
    chk("v5_lat_lit", e_lat, 1);
    chk("v5_qp_cr", int'(bus.out_qp_cr), 0);
    chk("v5_per_cb", int'(bus.out_per_cb), 0);
    chk("v5_rom_addr_held", int'(bus.rom_addr), a0);

    run_req("v6", 20, 0, 0, 0, 0, 3, 20, 5);
    chk("v6_cfg_err", int'(bus.out_cfg_err), 1);
    chk("v6_qp_cb", int'(bus.out_qp_cb), 20);
    chk("v6_per_cb", int'(bus.out_per_cb), 3);
    chk("v6_rem_cb", int'(bus.out_rem_cb), 2);

    // Abort in CR_DIV: nine negedges after the accepting edge.
    live = 1'b0;
    start_req(30, 0, 0, 0, 0, 1, 8);
    repeat (8) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_out_valid", int'(bus.out_valid), 0);
    chk("abort_in_ready", int'(bus.in_ready), 1);
    chk("abort_qp_cb", int'(bus.out_qp_cb), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (bus.out_valid) chk("abort_no_result", 1, 0);
    end

    run_req("v7", 45, 0, 0, 0, 0, 1, 8, 2);
    chk("v7_qp_cb", int'(bus.out_qp_cb), 39);
    chk("v7_per_cr", int'(bus.out_per_cr), 6);
    chk("v7_rem_cr", int'(bus.out_rem_cr), 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
